// File: rtl/rgmii_rx_ddr_capture.sv
// rgmii_rx_ddr_capture
//   RGMII receive front end. Captures 4-bit DDR data and DDR control from the
//   PHY on both edges of rgmii_clk, realigns them into one GMII byte per cycle
//   and decodes RX_DV / RX_ER. While the line is idle, it also tracks the PHY
//   in-band link status.
//
// Ports
//   rgmii_clk          in   1  RX clock from the PHY; both edges are used
//   rst                in   1  synchronous active-high reset (rising edge)
//   rgmii_rx_ctl       in   1  DDR control: rise = RX_DV, fall = RX_DV ^ RX_ER
//   rgmii_rxd          in   4  DDR data: rise = bits[3:0], fall = bits[7:4]
//   mac_rx_data        out  8  GMII byte
//   mac_rx_data_valid  out  1  RX_DV for mac_rx_data
//   mac_rx_error       out  1  RX_ER for mac_rx_data
//   link_up            out  1  in-band link status
//   link_speed         out  2  in-band speed (00=10M, 01=100M, 10=1000M)
//   full_duplex        out  1  in-band duplex
//
// Latency: 2 rising edges from the rising-phase sample to the output register.

module rgmii_rx_ddr_capture #(
    parameter bit INBAND_STATUS_EN = 1'b1
) (
    input  logic       rgmii_clk,
    input  logic       rst,
    input  logic       rgmii_rx_ctl,
    input  logic [3:0] rgmii_rxd,
    output logic [7:0] mac_rx_data,
    output logic       mac_rx_data_valid,
    output logic       mac_rx_error,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex
);

    // Capture stage
    logic [3:0] r_d_r;
    logic       r_c_r;
    logic [3:0] r_d_f;
    logic       r_c_f;
    logic       r_rst_q;

    // Alignment stage
    logic [7:0] r_byte;
    logic       r_dv;
    logic       r_er;

    // Output stage
    logic [7:0] r_out_data;
    logic       r_out_dv;
    logic       r_out_er;
    logic       r_link_up;
    logic [1:0] r_link_speed;
    logic       r_full_duplex;

    logic       w_status_beat;

    // An idle beat with matching nibbles carries the PHY in-band status.
    assign w_status_beat = !r_dv && !r_er && (r_byte[3:0] == r_byte[7:4]);

    // Reset seen on the rising edge; lets the falling-edge flops clear on
    // the following falling edge while staying in the single clock domain.
    always_ff @(posedge rgmii_clk) begin
        r_rst_q <= rst;
    end

    always_ff @(negedge rgmii_clk) begin
        if (r_rst_q) begin
            r_d_f <= '0;
            r_c_f <= 1'b0;
        end else begin
            r_d_f <= rgmii_rxd;
            r_c_f <= rgmii_rx_ctl;
        end
    end

    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            r_d_r         <= '0;
            r_c_r         <= 1'b0;
            r_byte        <= '0;
            r_dv          <= 1'b0;
            r_er          <= 1'b0;
            r_out_data    <= '0;
            r_out_dv      <= 1'b0;
            r_out_er      <= 1'b0;
            r_link_up     <= 1'b0;
            r_link_speed  <= '0;
            r_full_duplex <= 1'b0;
        end else begin
            r_d_r      <= rgmii_rxd;
            r_c_r      <= rgmii_rx_ctl;

            // Falling half of the previous cycle is the high nibble.
            r_byte     <= {r_d_f, r_d_r};
            r_dv       <= r_c_r;
            r_er       <= r_c_r ^ r_c_f;

            r_out_data <= r_byte;
            r_out_dv   <= r_dv;
            r_out_er   <= r_er;

            if (INBAND_STATUS_EN && w_status_beat) begin
                r_link_up     <= r_byte[0];
                r_link_speed  <= r_byte[2:1];
                r_full_duplex <= r_byte[3];
            end
        end
    end

    assign mac_rx_data       = r_out_data;
    assign mac_rx_data_valid = r_out_dv;
    assign mac_rx_error      = r_out_er;
    assign link_up           = r_link_up;
    assign link_speed        = r_link_speed;
    assign full_duplex       = r_full_duplex;

endmodule

// File: tb/tb_rgmii_rx_ddr_capture.sv
// tb_rgmii_rx_ddr_capture
//   Drives GMII-level beats (byte, dv, er, rst) onto the RGMII DDR pins and
//   checks every cycle against a beat-history model: the output after rising
//   edge j is the beat sampled at edge j-2, or zero if rst was sampled at any
//   of edges j-2..j. Directed vectors additionally pin literal values.

module tb_rgmii_rx_ddr_capture;

    localparam int N = 4096;

    logic       rgmii_clk = 1'b0;
    logic       rst = 1'b1;
    logic       rgmii_rx_ctl = 1'b0;
    logic [3:0] rgmii_rxd = '0;
    logic [7:0] mac_rx_data;
    logic       mac_rx_data_valid;
    logic       mac_rx_error;
    logic       link_up;
    logic [1:0] link_speed;
    logic       full_duplex;

    rgmii_rx_ddr_capture #(.INBAND_STATUS_EN(1'b1)) dut (
        .rgmii_clk        (rgmii_clk),
        .rst              (rst),
        .rgmii_rx_ctl     (rgmii_rx_ctl),
        .rgmii_rxd        (rgmii_rxd),
        .mac_rx_data      (mac_rx_data),
        .mac_rx_data_valid(mac_rx_data_valid),
        .mac_rx_error     (mac_rx_error),
        .link_up          (link_up),
        .link_speed       (link_speed),
        .full_duplex      (full_duplex)
    );

    always #5 rgmii_clk = ~rgmii_clk;

    // Stimulus history, indexed by rising-edge number
    logic [7:0] st_d  [N];
    logic       st_dv [N];
    logic       st_er [N];
    logic       st_rst[N];

    // Hand-computed literal expectations
    logic       pin_en [N];
    logic [7:0] pin_d  [N];
    logic       pin_dv [N];
    logic       pin_er [N];
    logic       pin_sen[N];
    logic [3:0] pin_st [N];   // {full_duplex, link_speed, link_up}

    int tests = 0;
    int fails = 0;
    int k = 0;      // next edge index to be driven
    int cur = -1;   // most recent rising edge index

    task automatic chk(input string name, input int j, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s edge %0d: got 0x%0h expected 0x%0h", name, j, act, exp);
        end
    endtask

    // One rgmii_clk cycle of stimulus; beat is sampled on rising edge k
    task automatic drive(input logic [7:0] d, input logic dv, input logic er, input logic r);
        @(negedge rgmii_clk);
        #1;
        rgmii_rxd    = d[3:0];
        rgmii_rx_ctl = dv;
        rst          = r;
        st_d[k] = d; st_dv[k] = dv; st_er[k] = er; st_rst[k] = r;
        @(posedge rgmii_clk);
        cur = k;
        k++;
        #1;
        rgmii_rxd    = d[7:4];
        rgmii_rx_ctl = dv ^ er;
    endtask

    task automatic pin_beat(input int j, input logic [7:0] d, input logic dv, input logic er);
        pin_en[j] = 1'b1; pin_d[j] = d; pin_dv[j] = dv; pin_er[j] = er;
    endtask

    task automatic pin_status(input int j, input logic [3:0] s);
        pin_sen[j] = 1'b1; pin_st[j] = s;
    endtask

    // Compare process
    initial begin : compare
        logic [7:0] ed;
        logic       edv, eer;
        logic [3:0] mst;
        int         j;
        mst = '0;
        forever begin
            @(posedge rgmii_clk);
            #3;
            if (cur >= 0) begin
                j = cur;
                if (j >= 2 && !st_rst[j] && !st_rst[j-1] && !st_rst[j-2]) begin
                    ed = st_d[j-2]; edv = st_dv[j-2]; eer = st_er[j-2];
                end else begin
                    ed = '0; edv = 1'b0; eer = 1'b0;
                end
                if (st_rst[j])
                    mst = '0;
                else if (!edv && !eer && ed[3:0] == ed[7:4])
                    mst = ed[3:0];
                chk("data",  j, 32'(mac_rx_data), 32'(ed));
                chk("valid", j, 32'(mac_rx_data_valid), 32'(edv));
                chk("error", j, 32'(mac_rx_error), 32'(eer));
                chk("status", j, 32'({full_duplex, link_speed, link_up}), 32'(mst));
                if (pin_en[j]) begin
                    chk("pin_data",  j, 32'(mac_rx_data), 32'(pin_d[j]));
                    chk("pin_valid", j, 32'(mac_rx_data_valid), 32'(pin_dv[j]));
                    chk("pin_error", j, 32'(mac_rx_error), 32'(pin_er[j]));
                end
                if (pin_sen[j])
                    chk("pin_status", j, 32'({full_duplex, link_speed, link_up}), 32'(pin_st[j]));
            end
        end
    end

    initial begin : driver
        int base;
        logic [7:0] b;
        int r;
        for (int i = 0; i < N; i++) begin
            pin_en[i] = 1'b0; pin_sen[i] = 1'b0;
            st_d[i] = '0; st_dv[i] = 1'b0; st_er[i] = 1'b0; st_rst[i] = 1'b1;
        end

        // Reset: outputs zero from the first reset edge
        pin_beat(0, 8'h00, 1'b0, 1'b0);
        pin_status(0, 4'h0);
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);

        // Good byte, error during dv, false carrier
        pin_beat(k + 2, 8'hA5, 1'b1, 1'b0); drive(8'hA5, 1'b1, 1'b0, 1'b0);
        pin_beat(k + 2, 8'h3C, 1'b1, 1'b1); drive(8'h3C, 1'b1, 1'b1, 1'b0);
        pin_beat(k + 2, 8'h77, 1'b0, 1'b1); drive(8'h77, 1'b0, 1'b1, 1'b0);
        pin_status(k + 1, 4'h0);

        // In-band status, then nibble mismatch holds it
        pin_status(k + 2, 4'hD); drive(8'hDD, 1'b0, 1'b0, 1'b0);
        pin_status(k + 2, 4'hD); drive(8'h5D, 1'b0, 1'b0, 1'b0);
        drive(8'h5D, 1'b0, 1'b0, 1'b0);
        pin_status(k + 1, 4'hD);
        drive(8'h00, 1'b0, 1'b1, 1'b0);

        // Back-to-back frame
        base = k;
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0, 1'b0);
        drive(8'hD5, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 64; i++) drive(8'(i), 1'b1, 1'b0, 1'b0);
        pin_beat(base + 2, 8'h55, 1'b1, 1'b0);
        pin_beat(base + 9, 8'hD5, 1'b1, 1'b0);
        pin_beat(base + 10 + 63, 8'h40, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);

        // One-cycle reset mid-frame
        drive(8'h11, 1'b1, 1'b0, 1'b0);
        drive(8'h22, 1'b1, 1'b0, 1'b0);
        pin_beat(k, 8'h00, 1'b0, 1'b0);
        pin_status(k, 4'h0);
        drive(8'h33, 1'b1, 1'b0, 1'b1);
        pin_beat(k + 2, 8'h9E, 1'b1, 1'b0);
        drive(8'h9E, 1'b1, 1'b0, 1'b0);
        drive(8'h4B, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(0, 99));
            b = 8'($urandom);
            if (r < 2)
                drive(b, 1'($urandom), 1'($urandom), 1'b1);
            else if (r < 45)
                drive(b, 1'b1, ($urandom_range(0, 15) == 0), 1'b0);
            else if (r < 75)
                drive({b[3:0], b[3:0]}, 1'b0, 1'b0, 1'b0);
            else if (r < 90)
                drive(b, 1'b0, 1'b0, 1'b0);
            else
                drive(b, 1'($urandom), 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);

        @(posedge rgmii_clk);
        #4;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
